// File: rtl/qerv_pkg.sv
// Shared encodings and byte-select decode for the qerv data-bus interface.
package qerv_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned SEL_W = 4;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Byte lanes touched by an access of the given size at address offset lsb.
  function automatic logic [SEL_W-1:0] sel_from(input logic [1:0] size,
                                                input logic [1:0] lsb);
    logic [SEL_W-1:0] sel;
    case (size)
      SIZE_B:  sel = 4'b0001 << lsb;
      SIZE_H:  sel = lsb[1] ? 4'b1100 : 4'b0011;
      default: sel = 4'b1111;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/qerv_dbus_if.sv
// Data-bus interface: one Wishbone classic transaction per request, read-data
// capture with a load strobe, and the serial byte-valid qualifier.
module qerv_dbus_if
  import qerv_pkg::*;
#(
  parameter int unsigned W              = 1,
  parameter bit          MISALIGN_CHECK = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req,
  input  logic             i_we,
  input  logic [1:0]       i_size,
  input  logic [1:0]       i_lsb,
  input  logic [XLEN-1:0]  i_adr,
  input  logic [XLEN-1:0]  i_wdat,
  input  logic [4:0]       i_cnt,
  output logic             o_byte_valid,
  output logic             o_misalign,
  output logic             o_busy,
  output logic             o_load,
  output logic             o_ack,
  output logic [XLEN-1:0]  o_rdat,
  output logic [XLEN-1:0]  o_wb_adr,
  output logic [XLEN-1:0]  o_wb_dat,
  output logic [SEL_W-1:0] o_wb_sel,
  output logic             o_wb_we,
  output logic             o_wb_cyc,
  input  logic [XLEN-1:0]  i_wb_rdt,
  input  logic             i_wb_ack
);

  state_e           state_q, state_d;
  logic [XLEN-1:0]  adr_q, adr_d;
  logic [XLEN-1:0]  dat_q, dat_d;
  logic [XLEN-1:0]  rdat_q, rdat_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             we_q, we_d;
  logic             cyc_q, cyc_d;
  logic             ack_q, ack_d;
  logic             load_q, load_d;
  logic             unused_ok;

  // Low address bits arrive separately on i_lsb; sub-byte count bits and the
  // datapath width only set the step of i_cnt and do not affect lane decode.
  assign unused_ok = ^{i_adr[1:0], i_cnt[2:0], 1'(W)};

  // Misalignment decode; size 11 behaves as a word access.
  always_comb begin
    o_misalign = 1'b0;
    if (MISALIGN_CHECK) begin
      case (i_size)
        SIZE_B:  o_misalign = 1'b0;
        SIZE_H:  o_misalign = i_lsb[0];
        default: o_misalign = |i_lsb;
      endcase
    end
  end

  // Serial cycle lies in a valid lane once its byte index reaches the offset.
  assign o_byte_valid = (i_cnt[4:3] >= i_lsb);

  // State and capture registers; reset drops the bus cycle immediately.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      adr_q   <= '0;
      dat_q   <= '0;
      rdat_q  <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      cyc_q   <= 1'b0;
      ack_q   <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      rdat_q  <= rdat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      cyc_q   <= cyc_d;
      ack_q   <= ack_d;
      load_q  <= load_d;
    end
  end

  // Next-state and next-output logic for the single-transaction FSM.
  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    rdat_d  = rdat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    case (state_q)
      IDLE: begin
        if (i_req && !o_misalign) begin
          state_d = BUSY;
          adr_d   = {i_adr[XLEN-1:2], 2'b00};
          dat_d   = i_wdat;
          we_d    = i_we;
          sel_d   = sel_from(i_size, i_lsb);
        end
      end
      BUSY: begin
        if (i_wb_ack) begin
          state_d = DONE;
          if (!we_q) rdat_d = i_wb_rdt;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    cyc_d  = (state_d == BUSY);
    ack_d  = (state_d == DONE);
    load_d = (state_d == DONE) && !we_d;
  end

  assign o_busy   = cyc_q;
  assign o_wb_cyc = cyc_q;
  assign o_ack    = ack_q;
  assign o_load   = load_q;
  assign o_rdat   = rdat_q;
  assign o_wb_adr = adr_q;
  assign o_wb_dat = dat_q;
  assign o_wb_sel = sel_q;
  assign o_wb_we  = we_q;

endmodule

// File: doc/qerv_dbus_if.md
Name: qerv_dbus_if

Overview:
- Data-bus interface stage directly next to the serial data buffer register.
- Takes the 32-bit store word and aligned address assembled during init and runs one Wishbone classic data transaction.
- Captures read data, then presents it to the buffer with a one-cycle load strobe.
- Generates the per-cycle byte-valid qualifier the buffer uses to shift store/load data into position.

Parameters:
- W, 1, serial datapath width in bits per cycle (1, 2, 4 or 8); sets the bit-position step of i_cnt.
- MISALIGN_CHECK, 1, 1 = detect misaligned accesses and suppress the bus cycle; 0 = never flag, always issue.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- i_req  in  1  start data transaction (single-cycle pulse from state logic)
- i_we  in  1  1 = store, 0 = load
- i_size  in  2  00 = byte, 01 = half, 10 = word; 11 is treated as word
- i_lsb  in  2  address bits [1:0]
- i_adr  in  32  byte address from buffer register
- i_wdat  in  32  store word from data buffer
- i_cnt  in  5  bit position of the current serial cycle (multiple of W)
- o_byte_valid  out  1  current serial cycle lies in a valid byte lane
- o_misalign  out  1  combinational misalignment flag for the current i_size/i_lsb
- o_busy  out  1  transaction outstanding
- o_load  out  1  one-cycle strobe: o_rdat valid, load into buffer
- o_ack  out  1  one-cycle completion strobe to state logic
- o_rdat  out  32  registered read data
- o_wb_adr  out  32  bus address, word aligned
- o_wb_dat  out  32  bus write data
- o_wb_sel  out  4  byte selects
- o_wb_we  out  1  bus write enable
- o_wb_cyc  out  1  cycle/strobe (stb tied equal to cyc)
- i_wb_rdt  in  32  bus read data
- i_wb_ack  in  1  bus acknowledge

Behaviour:
- Reset (async, immediate): state IDLE. o_wb_cyc, o_load, o_ack, o_busy = 0. o_rdat, o_wb_adr, o_wb_dat = 0. o_wb_sel = 0. o_wb_we = 0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - i_req & !o_misalign -> BUSY.
  - On the same edge, register o_wb_adr = {i_adr[31:2],2'b00}, o_wb_dat = i_wdat, o_wb_we = i_we, and o_wb_sel from the sel table below.
- IDLE, misaligned request: i_req & o_misalign -> stay IDLE, no bus cycle, no o_ack. The trap path consumes o_misalign.
- BUSY:
  - o_wb_cyc = o_busy = 1; all bus outputs held stable.
  - On i_wb_ack -> DONE. If !we, o_rdat <= i_wb_rdt on the same edge.
  - Writes leave o_rdat unchanged.
- DONE:
  - Exactly one cycle.
  - o_ack = 1; o_load = 1 only for loads.
  - -> IDLE.
- Latency: ack seen at edge N gives o_load/o_ack high in cycle N+1. Minimum request-to-ack is 1 cycle of cyc.
- i_req in BUSY or DONE: ignored (no queueing).
- i_wb_ack in IDLE or DONE: ignored.
- Reset mid-transaction: o_wb_cyc drops asynchronously; no o_ack is produced.
- Sel table:
  - byte: 4'b0001 << i_lsb.
  - half: i_lsb[1] ? 4'b1100 : 4'b0011.
  - word: 4'b1111.
- o_misalign = MISALIGN_CHECK & ((half & i_lsb[0]) | (word & |i_lsb)). Byte accesses never misalign.
- o_byte_valid = (i_cnt[4:3] >= i_lsb). Purely combinational, independent of state.

Decomposition:
- Shared package (qerv_pkg):
  - size encodings SIZE_B/SIZE_H/SIZE_W;
  - state encoding IDLE/BUSY/DONE;
  - function sel_from(size, lsb).
- No sub-module; the FSM, capture registers and combinational decode stay in one file.

Test Plan:
- Word load, lsb=0, ack after 3 cycles, i_wb_rdt=0xDEADBEEF -> sel=4'b1111, cyc high exactly 3 cycles, o_rdat=0xDEADBEEF, o_load=o_ack=1 for one cycle after ack.
- Byte store, adr=0x1003, wdat=0x11223344 -> o_wb_adr=0x1000, sel=4'b1000, we=1, o_ack pulse, o_load stays 0, o_rdat unchanged.
- Half load, lsb=1 -> o_misalign=1, cyc never rises, no o_ack. With MISALIGN_CHECK=0: o_misalign=0, cycle issued with sel=4'b0011.
- Second i_req while BUSY, with i_adr changed -> o_wb_adr unchanged, exactly one o_ack total.
- i_rst asserted while BUSY -> cyc=0 with no clock edge, state IDLE, no o_ack/o_load. A later request completes normally.
- lsb=2, sweep i_cnt 0..31 step W -> o_byte_valid=0 for cnt<16, 1 for cnt>=16; spurious i_wb_ack in IDLE -> no effect.
